posi_ref_fetch: RTL and testbench
=================================

POSI_REF_FETCH -- requirements
Module: posi_ref_fetch

Interface
REQ-001 clk  input  1  system clock; all state changes on rising edge.
REQ-002 rstn  input  1  reset, asynchronous, active-low.
REQ-003 start_i  input  1  one-cycle fetch request pulse from the post-intra controller.
REQ-004 size_i  input  2  block size: 0=4x4, 1=8x8, 2=16x16, 3=32x32; sampled with start_i.
REQ-005 position_i  input  8  z-scan index of the block's top-left 4x4 unit inside the 32x32 CU; sampled with start_i.
REQ-006 done_o  output  1  one-cycle pulse: reference set for the request is complete.
REQ-007 busy_o  output  1  high while a request is in progress.
REQ-008 rd_ena_o  output  1  neighbour-buffer read strobe.
REQ-009 rd_sel_o  output  1  buffer select: 0=top line buffer, 1=left column buffer.
REQ-010 rd_adr_o  output  4  neighbour-buffer word address (one word = 4 pixels).
REQ-011 rd_dat_i  input  32  read data; valid exactly one cycle after rd_ena_o.
REQ-012 ref_wen_o  output  1  reference-buffer write strobe.
REQ-013 ref_adr_o  output  5  reference-buffer word address.
REQ-014 ref_dat_o  output  32  reference-buffer write data.

Function
REQ-015 States SHALL be IDLE, TOP, LEFT, FLUSH; reset state IDLE.
REQ-016 In IDLE, start_i=1 SHALL latch size_i and position_i and move to TOP next cycle; start_i outside IDLE SHALL be ignored, with no effect on the running request.
REQ-017 Latched position SHALL have its low 2*size bits forced to zero before use (misaligned requests fetch the aligned enclosing block).
REQ-018 Block origin in 4-pixel units: x4={p[6],p[4],p[2],p[0]}, y4={p[7],p[5],p[3],p[1]} (p = masked position).
REQ-019 Word count W=2N/4 with N=4<<size (W=2,4,8,16); a 4-bit index i SHALL count 0..W-1 per phase.
REQ-020 TOP SHALL last exactly W cycles with rd_ena_o=1, rd_sel_o=0, rd_adr_o=x4+i (4-bit, no wrap occurs for legal inputs); then go to LEFT.
REQ-021 LEFT SHALL last exactly W cycles with rd_ena_o=1, rd_sel_o=1, rd_adr_o=y4+i; then go to FLUSH.
REQ-022 FLUSH SHALL last one cycle with rd_ena_o=0, then return to IDLE.
REQ-023 rd_ena_o, rd_sel_o, rd_adr_o SHALL be combinational from state and i; in IDLE/FLUSH rd_ena_o=0, rd_sel_o=0, rd_adr_o=0.
REQ-024 ref_wen_o SHALL be rd_ena_o delayed one cycle (registered); ref_adr_o SHALL be registered as i for top words and 16+i for left words.
REQ-025 ref_dat_o SHALL equal rd_dat_i combinationally, so data and ref_wen_o coincide.
REQ-026 Start accepted at cycle T: rd_ena_o high T+1..T+2W; ref_wen_o high T+2..T+2W+1; FLUSH at T+2W+1; done_o high only at T+2W+2.
REQ-027 done_o SHALL be registered, high for exactly one cycle per accepted request.
REQ-028 busy_o SHALL be 1 in TOP, LEFT, FLUSH and 0 in IDLE; the cycle done_o is high, state is IDLE, and a new start_i there SHALL be accepted (back-to-back, no gap).

Reset
REQ-029 rstn low SHALL immediately force state IDLE, i=0, latched size/position=0, done_o=0, busy_o=0, ref_wen_o=0, ref_adr_o=0; rd_* outputs follow IDLE values.
REQ-030 Reset mid-request SHALL abandon it without done_o; first request after reset release SHALL behave per REQ-026.

Verification
REQ-031 size=0, position=0x00, start at T -> rd_adr 0,1 (sel 0) at T+1,T+2; 0,1 (sel 1) at T+3,T+4; ref_adr 0,1,16,17 at T+2..T+5; done_o at T+6.
REQ-032 size=1, position=0x0C (x4=2, y4=2) -> top rd_adr 2,3,4,5; left rd_adr 2,3,4,5; done_o at T+10.
REQ-033 size=3, position=0x00 -> 32 reads, top/left rd_adr 0..15; ref_adr 0..15 then 16..31; done_o at T+34; rd_dat_i pattern 0xA0000000+adr appears unchanged on ref_dat_o.
REQ-034 size=1, position=0x07 (misaligned) -> treated as 0x04: x4=2, y4=0; top rd_adr 2..5, left 0..3.
REQ-035 start_i pulsed at T+3 during a size-2 request, then again in the done_o cycle -> first ignored; second accepted, rd_ena_o high next cycle, busy_o continuous.
REQ-036 rstn low at T+5 of a size-2 request, released, new size-0 start -> no done_o for aborted request; new request completes per REQ-031 timing.

Source files
------------

// File: rtl/posi_ref_fetch.sv
// Reference-sample fetch for the post-intra stage.
// Each accepted request reads W top-line words, then W left-column words,
// from the neighbour buffers. Each word is copied into the reference buffer:
// top words go to addresses 0..W-1 and left words go to 16..16+W-1.
module posi_ref_fetch (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start_i,
    input  logic [1:0]  size_i,
    input  logic [7:0]  position_i,
    output logic        done_o,
    output logic        busy_o,
    output logic        rd_ena_o,
    output logic        rd_sel_o,
    output logic [3:0]  rd_adr_o,
    input  logic [31:0] rd_dat_i,
    output logic        ref_wen_o,
    output logic [4:0]  ref_adr_o,
    output logic [31:0] ref_dat_o
);

    typedef enum logic [1:0] {IDLE, TOP, LEFT, FLUSH} state_t;

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [1:0]  size_q, size_d;
    logic [7:0]  pos_q, pos_d;
    logic        done_q, done_d;
    logic        ref_wen_q, ref_wen_d;
    logic [4:0]  ref_adr_q, ref_adr_d;

    logic [7:0]  pos_mask;
    logic [3:0]  x4, y4;
    logic [3:0]  idx_last;

    // Derive the alignment mask and the block origin in 4-pixel units.
    // The origin comes from de-interleaving the z-scan index: even bits
    // give x and odd bits give y.
    always_comb begin
        pos_mask = 8'hFF << {size_i, 1'b0};
        x4       = {pos_q[6], pos_q[4], pos_q[2], pos_q[0]};
        y4       = {pos_q[7], pos_q[5], pos_q[3], pos_q[1]};
        case (size_q)
            2'd0:    idx_last = 4'd1;
            2'd1:    idx_last = 4'd3;
            2'd2:    idx_last = 4'd7;
            default: idx_last = 4'd15;
        endcase
    end

    // Compute the next state and the combinational read strobe, select and address.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        size_d   = size_q;
        pos_d    = pos_q;
        rd_ena_o = 1'b0;
        rd_sel_o = 1'b0;
        rd_adr_o = 4'd0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    size_d  = size_i;
                    pos_d   = position_i & pos_mask;
                    idx_d   = 4'd0;
                    state_d = TOP;
                end
            end
            TOP: begin
                rd_ena_o = 1'b1;
                rd_adr_o = x4 + idx_q;
                if (idx_q == idx_last) begin
                    idx_d   = 4'd0;
                    state_d = LEFT;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            LEFT: begin
                rd_ena_o = 1'b1;
                rd_sel_o = 1'b1;
                rd_adr_o = y4 + idx_q;
                if (idx_q == idx_last) begin
                    idx_d   = 4'd0;
                    state_d = FLUSH;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            FLUSH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Write-side controls lag the read by one cycle, lining up with the
    // returning read data. Bit 4 of the reference address selects the left half.
    always_comb begin
        ref_wen_d = rd_ena_o;
        ref_adr_d = {rd_sel_o, idx_q};
        done_d    = (state_q == FLUSH);
    end

    // State and pipeline registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            idx_q     <= 4'd0;
            size_q    <= 2'd0;
            pos_q     <= 8'd0;
            done_q    <= 1'b0;
            ref_wen_q <= 1'b0;
            ref_adr_q <= 5'd0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            size_q    <= size_d;
            pos_q     <= pos_d;
            done_q    <= done_d;
            ref_wen_q <= ref_wen_d;
            ref_adr_q <= ref_adr_d;
        end
    end

    assign done_o    = done_q;
    assign busy_o    = (state_q != IDLE);
    assign ref_wen_o = ref_wen_q;
    assign ref_adr_o = ref_adr_q;
    assign ref_dat_o = rd_dat_i;

endmodule

// File: tb/tb_posi_ref_fetch.sv
// Bench for posi_ref_fetch.
// The bench drives requests from a vector table and models the neighbour
// buffer. Expected reads and writes are queued when a request is launched,
// and consumed as the DUT strobes rd_ena_o / ref_wen_o.
module tb_posi_ref_fetch;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start_i = 1'b0;
    logic [1:0]  size_i = 2'd0;
    logic [7:0]  position_i = 8'd0;
    logic        done_o, busy_o, rd_ena_o, rd_sel_o, ref_wen_o;
    logic [3:0]  rd_adr_o;
    logic [31:0] rd_dat_i = 32'd0;
    logic [4:0]  ref_adr_o;
    logic [31:0] ref_dat_o;

    posi_ref_fetch dut (
        .clk(clk), .rstn(rstn), .start_i(start_i), .size_i(size_i),
        .position_i(position_i), .done_o(done_o), .busy_o(busy_o),
        .rd_ena_o(rd_ena_o), .rd_sel_o(rd_sel_o), .rd_adr_o(rd_adr_o),
        .rd_dat_i(rd_dat_i), .ref_wen_o(ref_wen_o), .ref_adr_o(ref_adr_o),
        .ref_dat_o(ref_dat_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [1:0] size;
        logic [7:0] pos;
        logic [3:0] x4;
        logic [3:0] y4;
    } vec_t;

    typedef struct { logic sel; logic [3:0] adr; } rd_exp_t;
    typedef struct { logic [4:0] adr; logic [31:0] dat; } ref_exp_t;

    rd_exp_t  rd_q[$];
    ref_exp_t ref_q[$];
    vec_t     vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Neighbour buffer contents: each word encodes its own select and address.
    function automatic logic [31:0] dat_of(input logic sel, input logic [3:0] adr);
        return 32'hA000_0000 | {23'd0, sel, 4'd0, adr};
    endfunction

    // Monitor and buffer model. It consumes expected reads and writes,
    // then schedules the read data for the following cycle.
    logic [31:0] nxt_dat = 32'h5555_5555;
    always @(negedge clk) begin
        rd_exp_t  rx;
        ref_exp_t wx;
        if (ref_wen_o) begin
            if (ref_q.size() == 0) chk("ref_unexpected", 32'd1, 32'd0);
            else begin
                wx = ref_q.pop_front();
                chk("ref_adr", 32'(ref_adr_o), 32'(wx.adr));
                chk("ref_dat", ref_dat_o, wx.dat);
            end
        end
        if (rd_ena_o) begin
            if (rd_q.size() == 0) chk("rd_unexpected", 32'd1, 32'd0);
            else begin
                rx = rd_q.pop_front();
                chk("rd_sel", 32'(rd_sel_o), 32'(rx.sel));
                chk("rd_adr", 32'(rd_adr_o), 32'(rx.adr));
            end
            nxt_dat = dat_of(rd_sel_o, rd_adr_o);
        end else begin
            nxt_dat = 32'h5555_5555;
        end
    end
    always @(posedge clk) begin
        #1;
        rd_dat_i = nxt_dat;
    end

    // Drive a start pulse and queue the expected read and write sequence.
    task automatic launch(input vec_t v);
        int w;
        logic [3:0] a;
        w = 2 << v.size;
        start_i    = 1'b1;
        size_i     = v.size;
        position_i = v.pos;
        for (int i = 0; i < w; i++) begin
            a = v.x4 + 4'(i);
            rd_q.push_back('{1'b0, a});
            ref_q.push_back('{5'(i), dat_of(1'b0, a)});
        end
        for (int i = 0; i < w; i++) begin
            a = v.y4 + 4'(i);
            rd_q.push_back('{1'b1, a});
            ref_q.push_back('{5'(16 + i), dat_of(1'b1, a)});
        end
    endtask

    // Follow one request cycle by cycle up to and including its done cycle.
    // With mid set, a stray start is pulsed at T+3. That start must be ignored.
    task automatic track(input int w, input bit mid);
        for (int k = 1; k <= 2*w + 2; k++) begin
            @(negedge clk);
            if (k == 1) start_i = 1'b0;
            chk("busy",   32'(busy_o),   32'(k <= 2*w + 1));
            chk("done",   32'(done_o),   32'(k == 2*w + 2));
            chk("rd_ena", 32'(rd_ena_o), 32'(k <= 2*w));
            if (mid && k == 3) begin
                start_i = 1'b1; size_i = 2'd0; position_i = 8'hFF;
            end
            if (mid && k == 4) start_i = 1'b0;
        end
        chk("rdq_empty",  32'(rd_q.size()),  32'd0);
        chk("refq_empty", 32'(ref_q.size()), 32'd0);
    endtask

    task automatic idle_chk();
        chk("idle_busy",   32'(busy_o),   32'd0);
        chk("idle_done",   32'(done_o),   32'd0);
        chk("idle_rd_ena", 32'(rd_ena_o), 32'd0);
        chk("idle_rd_sel", 32'(rd_sel_o), 32'd0);
        chk("idle_rd_adr", 32'(rd_adr_o), 32'd0);
        chk("idle_refwen", 32'(ref_wen_o), 32'd0);
    endtask

    initial begin
        // Each entry gives size, position, and the hand-derived x4 and y4 origin.
        vecs[0] = '{2'd0, 8'h00, 4'd0,  4'd0};
        vecs[1] = '{2'd1, 8'h0C, 4'd2,  4'd2};
        vecs[2] = '{2'd3, 8'h00, 4'd0,  4'd0};
        vecs[3] = '{2'd1, 8'h07, 4'd2,  4'd0};
        vecs[4] = '{2'd2, 8'h3F, 4'd4,  4'd4};
        vecs[5] = '{2'd0, 8'h9A, 4'd4,  4'd11};
        vecs[6] = '{2'd2, 8'hC0, 4'd8,  4'd8};

        // Check the reset state.
        repeat (2) @(negedge clk);
        idle_chk();
        chk("rst_ref_adr", 32'(ref_adr_o), 32'd0);
        rstn = 1'b1;
        @(negedge clk);
        idle_chk();

        // Run each table entry in isolation.
        foreach (vecs[n]) begin
            launch(vecs[n]);
            track(2 << vecs[n].size, 1'b0);
            @(negedge clk);
            idle_chk();
        end

        // Ignore a stray start mid-request, then accept a start in the done cycle.
        launch(vecs[4]);
        track(8, 1'b1);
        launch(vecs[0]);
        track(2, 1'b0);
        @(negedge clk);
        idle_chk();

        // Assert reset at T+5 of a size-2 request. It must abandon without done.
        launch(vecs[6]);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 1) start_i = 1'b0;
        end
        #2 rstn = 1'b0;
        #1;
        chk("abort_busy",    32'(busy_o),    32'd0);
        chk("abort_done",    32'(done_o),    32'd0);
        chk("abort_rd_ena",  32'(rd_ena_o),  32'd0);
        chk("abort_ref_wen", 32'(ref_wen_o), 32'd0);
        chk("abort_ref_adr", 32'(ref_adr_o), 32'd0);
        rd_q.delete();
        ref_q.delete();
        @(negedge clk);
        chk("abort_done2", 32'(done_o), 32'd0);
        rstn = 1'b1;
        @(negedge clk);
        idle_chk();
        launch(vecs[0]);
        track(2, 1'b0);
        @(negedge clk);
        idle_chk();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
